// File: rtl/hyperbus_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_mem_responder_pkg
// Description : Shared types and defaults for the HyperBus memory responder:
//               FSM state encoding, burst direction codes, default timing.
// Revision    : 1.0 - initial release
// ============================================================================
package hyperbus_mem_responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LAT     = 3'd1,
      ST_READ    = 3'd2,
      ST_WRITE   = 3'd3,
      ST_RECOVER = 3'd4
   } hbus_state_e;

   typedef enum logic {
      CMD_READ  = 1'b0,
      CMD_WRITE = 1'b1
   } hbus_cmd_e;

   localparam int DEF_LATENCY  = 6;
   localparam int DEF_RECOVERY = 2;

   // Latency and recovery counters share one 4-bit down-counter (range 1..15).
   localparam int CNT_WIDTH = 4;

   // Counter load value for a phase lasting 'cycles' cycles (counts down to 0).
   function automatic logic [CNT_WIDTH-1:0] cycles_to_cnt(input int cycles);
      return CNT_WIDTH'(cycles - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hyperbus_sp_ram.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_sp_ram
// Description : Single-port synchronous RAM, 1-cycle read latency, write-first.
//               Read data holds while the port is not enabled. No reset on the
//               array so contents survive a responder reset.
// Revision    : 1.0 - initial release
// ============================================================================
module hyperbus_sp_ram #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [1<<ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Enabled access: write updates array and forwards new data, read fetches.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
            rdata_q       <= wdata_i;
         end else begin
            rdata_q       <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/hyperbus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_mem_responder
// Description : HyperBus-style burst memory responder. Accepts read/write
//               bursts, waits LATENCY cycles, streams beats to/from a backing
//               RAM with no bubbles, then observes RECOVERY idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hyperbus_mem_responder
   import hyperbus_mem_responder_pkg::*;
#(
   parameter int HBUS_ADDR_WIDTH = 32,
   parameter int HBUS_DATA_WIDTH = 16,
   parameter int MEM_ADDR_WIDTH  = 10,
   parameter int LATENCY         = DEF_LATENCY,
   parameter int RECOVERY        = DEF_RECOVERY
) (
   input  logic                       hbus_clk,
   input  logic                       hbus_rst,
   input  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i,
   input  logic                       hbus_rrq,
   input  logic                       hbus_wrq,
   input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
   output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
   output logic                       hbus_ready,
   output logic                       hbus_valid,
   output logic                       hbus_busy
);

   localparam logic [MEM_ADDR_WIDTH-1:0] c_ptr_one   = MEM_ADDR_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]      c_lat_cnt   = cycles_to_cnt(LATENCY);
   localparam logic [CNT_WIDTH-1:0]      c_rec_cnt   = (RECOVERY == 0) ? '0 : cycles_to_cnt(RECOVERY);
   localparam hbus_state_e               c_rec_state = (RECOVERY == 0) ? ST_IDLE : ST_RECOVER;

   hbus_state_e                state_q, state_d;
   hbus_cmd_e                  dir_q,   dir_d;
   logic [CNT_WIDTH-1:0]       cnt_q,   cnt_d;
   logic [MEM_ADDR_WIDTH-1:0]  ptr_q,   ptr_d;
   logic [HBUS_DATA_WIDTH-1:0] dat_o_q, dat_o_d;
   logic                       valid_q, valid_d;
   logic                       ready_q, ready_d;
   logic                       busy_q,  busy_d;

   logic                       ram_en;
   logic                       ram_we;
   logic [MEM_ADDR_WIDTH-1:0]  ram_addr;
   logic [HBUS_DATA_WIDTH-1:0] ram_rdata;
   logic [MEM_ADDR_WIDTH-1:0]  ptr_inc;
   logic                       req_active;

   // Upper address bits select nothing in the backing RAM.
   generate
      if (HBUS_ADDR_WIDTH > MEM_ADDR_WIDTH) begin : g_adr_unused
         logic w_unused_adr;
         assign w_unused_adr = ^hbus_adr_i[HBUS_ADDR_WIDTH-1:MEM_ADDR_WIDTH];
      end
   endgenerate

   assign ptr_inc    = ptr_q + c_ptr_one;
   assign req_active = (dir_q == CMD_READ) ? hbus_rrq : hbus_wrq;

   // Next-state, RAM port control and registered-output next values.
   // Reads are prefetched: the start address is fetched as the request is
   // accepted, and ptr+1 is fetched as each beat is presented, so the RAM
   // output always holds the beat after the one on hbus_dat_o.
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      dat_o_d  = dat_o_q;
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = ptr_q;

      case (state_q)
         ST_IDLE: begin
            if (hbus_rrq || hbus_wrq) begin
               dir_d   = hbus_rrq ? CMD_READ : CMD_WRITE;
               ptr_d   = hbus_adr_i[MEM_ADDR_WIDTH-1:0];
               cnt_d   = c_lat_cnt;
               state_d = ST_LAT;
               if (hbus_rrq) begin
                  ram_en   = 1'b1;
                  ram_addr = hbus_adr_i[MEM_ADDR_WIDTH-1:0];
               end
            end
         end
         ST_LAT: begin
            if (!req_active) begin
               state_d = c_rec_state;
               cnt_d   = c_rec_cnt;
            end else if (cnt_q == '0) begin
               if (dir_q == CMD_READ) begin
                  state_d  = ST_READ;
                  dat_o_d  = ram_rdata;
                  ram_en   = 1'b1;
                  ram_addr = ptr_inc;
                  ptr_d    = ptr_inc;
               end else begin
                  state_d  = ST_WRITE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_READ: begin
            if (!hbus_rrq) begin
               state_d = c_rec_state;
               cnt_d   = c_rec_cnt;
            end else begin
               dat_o_d  = ram_rdata;
               ram_en   = 1'b1;
               ram_addr = ptr_inc;
               ptr_d    = ptr_inc;
            end
         end
         ST_WRITE: begin
            if (!hbus_wrq) begin
               state_d = c_rec_state;
               cnt_d   = c_rec_cnt;
            end else begin
               ram_en   = 1'b1;
               ram_we   = 1'b1;
               ram_addr = ptr_q;
               ptr_d    = ptr_inc;
            end
         end
         ST_RECOVER: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      valid_d = (state_d == ST_READ);
      ready_d = (state_d == ST_WRITE);
      busy_d  = (state_d != ST_IDLE);
   end

   // State and output registers; reset aborts any burst immediately.
   always_ff @(posedge hbus_clk or posedge hbus_rst) begin
      if (hbus_rst) begin
         state_q <= ST_IDLE;
         dir_q   <= CMD_READ;
         cnt_q   <= '0;
         ptr_q   <= '0;
         dat_o_q <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         dat_o_q <= dat_o_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign hbus_dat_o = dat_o_q;
   assign hbus_valid = valid_q;
   assign hbus_ready = ready_q;
   assign hbus_busy  = busy_q;

   hyperbus_sp_ram #(
      .ADDR_WIDTH (MEM_ADDR_WIDTH),
      .DATA_WIDTH (HBUS_DATA_WIDTH)
   ) u_ram (
      .clk_i   (hbus_clk),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (hbus_dat_i),
      .rdata_o (ram_rdata)
   );

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hyperbus_mem_responder
// Description : Self-checking bench for hyperbus_mem_responder. Requesters
//               push expected read beats into a queue; a monitor pops and
//               compares every valid beat against an array memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hyperbus_mem_responder;

   localparam int AW    = 32;
   localparam int DW    = 16;
   localparam int MW    = 10;
   localparam int LAT   = 6;
   localparam int REC   = 2;
   localparam int DEPTH = 1 << MW;

   logic          hbus_clk = 1'b0;
   logic          hbus_rst = 1'b1;
   logic [AW-1:0] hbus_adr_i = '0;
   logic          hbus_rrq = 1'b0;
   logic          hbus_wrq = 1'b0;
   logic [DW-1:0] hbus_dat_i = '0;
   logic [DW-1:0] hbus_dat_o;
   logic          hbus_ready;
   logic          hbus_valid;
   logic          hbus_busy;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] wbuf [$];
   logic [DW-1:0] last_dat = '0;

   hyperbus_mem_responder #(
      .HBUS_ADDR_WIDTH (AW),
      .HBUS_DATA_WIDTH (DW),
      .MEM_ADDR_WIDTH  (MW),
      .LATENCY         (LAT),
      .RECOVERY        (REC)
   ) dut (
      .hbus_clk   (hbus_clk),
      .hbus_rst   (hbus_rst),
      .hbus_adr_i (hbus_adr_i),
      .hbus_rrq   (hbus_rrq),
      .hbus_wrq   (hbus_wrq),
      .hbus_dat_i (hbus_dat_i),
      .hbus_dat_o (hbus_dat_o),
      .hbus_ready (hbus_ready),
      .hbus_valid (hbus_valid),
      .hbus_busy  (hbus_busy)
   );

   always #5 hbus_clk = ~hbus_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every valid beat must match the next expected word; while not
   // valid the read data must hold its previous value.
   always @(negedge hbus_clk) begin
      if (hbus_rst) begin
         last_dat = '0;
      end else if (hbus_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL read_beat: unexpected beat 0x%0h, none expected", hbus_dat_o);
         end else begin
            check("read_beat", hbus_dat_o, exp_q.pop_front());
         end
         last_dat = hbus_dat_o;
      end else begin
         check("dat_hold", hbus_dat_o, last_dat);
      end
   end

   // Read burst of n wanted beats; one trailing beat follows the drop of rrq.
   task automatic do_read(input logic [AW-1:0] adr, input int n, input bit with_wrq);
      int cyc = 0, beats = 0, first_v = -1, rise = -1;
      bit seen_low = 0, saw_ready = 0;
      for (int i = 0; i <= n; i++)
         exp_q.push_back(model_mem[(int'(adr[MW-1:0]) + i) % DEPTH]);
      hbus_adr_i = adr;
      hbus_rrq   = 1'b1;
      hbus_wrq   = with_wrq;
      hbus_dat_i = DW'($urandom);
      while (beats < n && cyc < n + LAT + REC + 20) begin
         @(negedge hbus_clk);
         if (!hbus_busy) seen_low = 1;
         else if (seen_low && rise < 0) rise = cyc;
         if (hbus_ready) saw_ready = 1;
         if (hbus_valid) begin
            if (first_v < 0) first_v = cyc;
            beats++;
         end
         cyc++;
         @(posedge hbus_clk);
         #1;
      end
      hbus_rrq = 1'b0;
      hbus_wrq = 1'b0;
      check("read_beats", beats, n);
      check("read_latency", first_v - rise, LAT);
      check("read_no_ready", saw_ready, 0);
      if (beats < n) exp_q.delete();
   endtask

   // Write burst of n beats from wbuf; model updated for committed beats.
   task automatic do_write(input logic [AW-1:0] adr, input int n);
      int cyc = 0, beats = 0, first_r = -1, rise = -1;
      bit seen_low = 0, saw_valid = 0;
      hbus_adr_i = adr;
      hbus_wrq   = 1'b1;
      hbus_dat_i = wbuf[0];
      while (beats < n && cyc < n + LAT + REC + 20) begin
         @(negedge hbus_clk);
         if (!hbus_busy) seen_low = 1;
         else if (seen_low && rise < 0) rise = cyc;
         if (hbus_valid) saw_valid = 1;
         if (hbus_ready) begin
            if (first_r < 0) first_r = cyc;
            beats++;
         end
         cyc++;
         @(posedge hbus_clk);
         #1;
         if (beats < n) hbus_dat_i = wbuf[beats];
      end
      hbus_wrq = 1'b0;
      for (int i = 0; i < beats; i++)
         model_mem[(int'(adr[MW-1:0]) + i) % DEPTH] = wbuf[i];
      check("write_beats", beats, n);
      check("write_latency", first_r - rise, LAT);
      check("write_no_valid", saw_valid, 0);
   endtask

   task automatic wait_idle();
      int cyc = 0;
      do begin
         @(negedge hbus_clk);
         cyc++;
      end while (hbus_busy && cyc < 40);
      check("idle_reached", hbus_busy, 0);
      @(posedge hbus_clk);
      #1;
   endtask

   logic [31:0] ra;
   int          rn, rk, busy_cnt, cyc;
   bit          saw, seen;

   initial begin
      // Reset state
      repeat (3) @(posedge hbus_clk);
      @(negedge hbus_clk);
      check("rst_valid", hbus_valid, 0);
      check("rst_ready", hbus_ready, 0);
      check("rst_busy",  hbus_busy,  0);
      check("rst_dat",   hbus_dat_o, 0);
      @(posedge hbus_clk);
      #1;
      hbus_rst = 1'b0;
      @(posedge hbus_clk);
      #1;

      // Fill the whole RAM so every later read has a known expectation
      wbuf.delete();
      for (int i = 0; i < DEPTH; i++) wbuf.push_back(DW'($urandom));
      do_write('0, DEPTH);
      wait_idle();

      // Basic write then read-back
      wbuf = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
      do_write(32'h10, 4);
      wait_idle();
      do_read(32'h10, 4, 1'b0);
      wait_idle();

      // Wrap at the top of the RAM
      wbuf = {16'hA001, 16'hA002, 16'hA003};
      do_write(32'h3FF, 3);
      wait_idle();
      check("wrap_model_0", model_mem[0], 16'hA002);
      do_read(32'h3FF, 3, 1'b0);
      wait_idle();

      // Read and write together: read wins, RAM untouched
      do_read(32'h20, 2, 1'b1);
      wait_idle();
      do_read(32'h20, 2, 1'b0);
      wait_idle();

      // Write request dropped in third latency cycle
      hbus_adr_i = 32'h30;
      hbus_dat_i = 16'hDEAD;
      hbus_wrq   = 1'b1;
      busy_cnt   = 0;
      saw        = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge hbus_clk);
         if (hbus_busy) busy_cnt++;
         if (hbus_ready) saw = 1;
         @(posedge hbus_clk);
         #1;
         if (c == 2) hbus_wrq = 1'b0;
      end
      check("abort_busy_cycles", busy_cnt, 3 + REC);
      check("abort_no_ready", saw, 0);
      do_read(32'h30, 2, 1'b0);
      wait_idle();

      // Reset during second beat of a 4-beat write
      wbuf.delete();
      for (int i = 0; i < 4; i++) wbuf.push_back(DW'($urandom));
      hbus_adr_i = 32'h50;
      hbus_dat_i = wbuf[0];
      hbus_wrq   = 1'b1;
      seen       = 0;
      cyc        = 0;
      while (!seen && cyc < 30) begin
         @(negedge hbus_clk);
         if (hbus_ready) seen = 1;
         cyc++;
         @(posedge hbus_clk);
         #1;
      end
      check("rst_first_ready", seen, 1);
      hbus_dat_i = wbuf[1];
      #2;
      hbus_rst = 1'b1;
      #1;
      check("midrst_valid", hbus_valid, 0);
      check("midrst_ready", hbus_ready, 0);
      check("midrst_busy",  hbus_busy,  0);
      check("midrst_dat",   hbus_dat_o, 0);
      hbus_wrq = 1'b0;
      @(posedge hbus_clk);
      #2;
      hbus_rst = 1'b0;
      model_mem[32'h50] = wbuf[0];
      wait_idle();
      do_read(32'h50, 4, 1'b0);
      wait_idle();

      // Back-to-back: new read raised during recovery
      do_read(32'h40, 3, 1'b0);
      @(posedge hbus_clk);
      #1;
      do_read(32'h80, 2, 1'b0);
      wait_idle();

      // Randomized traffic (upper address bits random and ignored)
      repeat (24) begin
         ra = $urandom;
         rn = $urandom_range(1, 8);
         rk = $urandom_range(0, 2);
         if (rk == 0) begin
            wbuf.delete();
            for (int i = 0; i < rn; i++) wbuf.push_back(DW'($urandom));
            do_write(ra, rn);
         end else begin
            do_read(ra, rn, rk == 2);
         end
         wait_idle();
      end

      check("exp_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
